// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI slave in front of a word-addressed RAM.
// Define AXI_SLV_STALL_EN to add LFSR-driven ready and response stalls.
module axi_sram_slave #(
  parameter int         MEM_AW     = 12,
  parameter int         RD_LAT     = 1,
  parameter logic [7:0] STALL_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_LAT    = 2'd1;
  localparam logic [1:0] R_RESP   = 2'd2;
  localparam logic [0:0] W_IDLE   = 1'b0;
  localparam logic [0:0] W_RESP   = 1'b1;
  localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

  logic [31:0] mem [2**MEM_AW];

  logic alive;
  logic stall;

`ifdef AXI_SLV_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= STALL_SEED;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = lfsr[0];
`else
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
  assign stall = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^{araddr[31:MEM_AW+2], araddr[1:0],
                         awaddr[31:MEM_AW+2], awaddr[1:0]};

  // Readies stay low through the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (!resetn) alive <= 1'b0;
    else alive <= 1'b1;
  end

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  logic [1:0]        r_st;
  logic [3:0]        r_cnt;
  logic [3:0]        r_cnt_dec;
  logic [MEM_AW-1:0] r_idx;
  logic [MEM_AW-1:0] ar_idx;
  logic [MEM_AW-1:0] rd_idx;
  logic              ar_hs;
  logic              r_enter;
  logic [31:0]       rd_word;

  logic [0:0]        w_st;
  logic              aw_got;
  logic              w_got;
  logic [MEM_AW-1:0] aw_idx;
  logic [3:0]        aw_id_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_hs;
  logic              w_hs;
  logic              w_commit;
  logic [MEM_AW-1:0] c_idx;
  logic [3:0]        c_id;
  logic [31:0]       c_data;
  logic [3:0]        c_strb;
  logic [31:0]       wr_word;

  assign arready = alive && (r_st == R_IDLE) && !stall;
  assign awready = alive && (w_st == W_IDLE) && !aw_got && !stall;
  assign wready  = alive && (w_st == W_IDLE) && !w_got && !stall;

  assign rvalid = (r_st == R_RESP);
  assign rlast  = rvalid;
  assign rresp  = 2'b00;
  assign bvalid = (w_st == W_RESP);
  assign bresp  = 2'b00;

  assign ar_hs     = arvalid && arready;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign ar_idx    = araddr[MEM_AW+1:2];
  assign r_cnt_dec = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;

  always_comb begin
    r_enter = 1'b0;
    rd_idx  = r_idx;
    unique case (r_st)
      R_IDLE: begin
        rd_idx  = ar_idx;
        r_enter = ar_hs && (LAT_INIT == 4'd0);
      end
      R_LAT:   r_enter = (r_cnt_dec == 4'd0) && !stall;
      default: r_enter = 1'b0;
    endcase
  end

  assign c_idx  = aw_got ? aw_idx : awaddr[MEM_AW+1:2];
  assign c_id   = aw_got ? aw_id_q : awid;
  assign c_data = w_got ? wdata_q : wdata;
  assign c_strb = w_got ? wstrb_q : wstrb;

  assign w_commit = resetn && (w_st == W_IDLE) && !stall &&
                    (aw_got || aw_hs) && (w_got || w_hs);

  assign wr_word = merge(mem[c_idx], c_data, c_strb);

  // Write-first: a commit to the sampled word is visible in rdata.
  assign rd_word = (w_commit && (c_idx == rd_idx)) ? wr_word : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (w_commit) mem[c_idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_st  <= R_IDLE;
      r_cnt <= 4'd0;
      r_idx <= '0;
      rid   <= 4'd0;
      rdata <= 32'd0;
    end else begin
      if (r_enter) rdata <= rd_word;
      unique case (r_st)
        R_IDLE: begin
          if (ar_hs) begin
            rid   <= arid;
            r_idx <= ar_idx;
            r_cnt <= LAT_INIT;
            r_st  <= r_enter ? R_RESP : R_LAT;
          end
        end
        R_LAT: begin
          r_cnt <= r_cnt_dec;
          if (r_enter) r_st <= R_RESP;
        end
        R_RESP: begin
          if (rready) r_st <= R_IDLE;
        end
        default: r_st <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_st    <= W_IDLE;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_idx  <= '0;
      aw_id_q <= 4'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      bid     <= 4'd0;
    end else begin
      if (aw_hs) begin
        aw_got  <= 1'b1;
        aw_idx  <= awaddr[MEM_AW+1:2];
        aw_id_q <= awid;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (w_st == W_IDLE) begin
        if (w_commit) begin
          w_st <= W_RESP;
          bid  <= c_id;
        end
      end else if (bready) begin
        w_st   <= W_IDLE;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed AXI read/write vectors plus a
// randomized scoreboard run against axi_sram_slave.
`timescale 1ns/1ps
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [3:0] id,
                    output int blat, output logic [3:0] b_id);
    bit ad = 0;
    bit wd = 0;
    bit ah, wh;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awid = id;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(ad && wd) && n < 200) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(negedge clk);
      n++;
      if (ah) begin ad = 1; awvalid = 1'b0; end
      if (wh) begin wd = 1; wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_hs_timeout", 32'(ad && wd), 1);
    blat = 0;
    while (!bvalid && blat < 200) begin
      @(negedge clk);
      blat++;
    end
    chk("wr_b_timeout", 32'(bvalid), 1);
    chk("bresp", 32'(bresp), 0);
    b_id = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] id,
                    input int hold, output logic [31:0] d,
                    output logic [3:0] r_id, output int rlat,
                    output logic ar_after);
    bit ad = 0;
    bit ah;
    int n = 0;
    araddr = a; arid = id; arvalid = 1'b1; rready = 1'b0;
    while (!ad && n < 200) begin
      ah = arvalid && arready;
      @(negedge clk);
      n++;
      if (ah) begin ad = 1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    chk("rd_hs_timeout", 32'(ad), 1);
    rlat = 0;
    while (!rvalid && rlat < 200) begin
      @(negedge clk);
      rlat++;
    end
    chk("rd_r_timeout", 32'(rvalid), 1);
    chk("rlast", 32'(rlast), 1);
    chk("rresp", 32'(rresp), 0);
    d = rdata;
    r_id = rid;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("r_hold_valid", 32'(rvalid), 1);
      chk("r_hold_data", rdata, d);
      chk("r_hold_id", 32'(rid), 32'(r_id));
      chk("r_hold_arready", 32'(arready), 0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    ar_after = arready;
  endtask

  int          blat, rlat;
  logic [3:0]  bi, ri;
  logic [31:0] rdv;
  logic        aa;
  logic [31:0] mdl [16];
  logic [31:0] a, d, e;
  logic [3:0]  s;
  int          k, nops;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rid", 32'(rid), 0);
    chk("rst_bid", 32'(bid), 0);
    chk("rst_rdata", rdata, 0);
    resetn = 1'b1;
    @(negedge clk);

`ifndef AXI_SLV_STALL_EN
    wr(32'h10, 32'h12345678, 4'hF, 4'd1, blat, bi);
    chk("t1_blat", 32'(blat), 0);
    chk("t1_bid", 32'(bi), 1);
    rd(32'h10, 4'd0, 0, rdv, ri, rlat, aa);
    chk("t1_rlat", 32'(rlat), 0);
    chk("t1_rdata", rdv, 32'h12345678);
    chk("t1_rid", 32'(ri), 0);

    wr(32'h10, 32'hAABBCCDD, 4'b0101, 4'd2, blat, bi);
    rd(32'h10, 4'd5, 0, rdv, ri, rlat, aa);
    chk("t2_rdata", rdv, 32'h12BB56DD);
    chk("t2_rid", 32'(ri), 5);

    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("t3_wready_low", 32'(wready), 0);
    chk("t3_no_b", 32'(bvalid), 0);
    @(negedge clk);
    @(negedge clk);
    awaddr = 32'h30; awid = 4'd6; awvalid = 1'b1;
    chk("t3_awready", 32'(awready), 1);
    @(negedge clk);
    awvalid = 1'b0;
    chk("t3_bvalid", 32'(bvalid), 1);
    chk("t3_bid", 32'(bid), 6);
    @(negedge clk);
    bready = 1'b0;
    chk("t3_b_done", 32'(bvalid), 0);
    rd(32'h30, 4'd3, 0, rdv, ri, rlat, aa);
    chk("t3_rdata", rdv, 32'h0BADF00D);

    rd(32'h10, 4'd9, 5, rdv, ri, rlat, aa);
    chk("t4_rdata", rdv, 32'h12BB56DD);
    chk("t4_rid", 32'(ri), 9);
    chk("t4_ar_next", 32'(aa), 1);

    wr(32'h4000, 32'hCAFEF00D, 4'hF, 4'd2, blat, bi);
    rd(32'h0, 4'd1, 0, rdv, ri, rlat, aa);
    chk("t5_alias0", rdv, 32'hCAFEF00D);
    rd(32'h8000_0002, 4'd1, 0, rdv, ri, rlat, aa);
    chk("t5_alias_hi", rdv, 32'hCAFEF00D);

    wr(32'h20, 32'h11111111, 4'hF, 4'd4, blat, bi);
    fork
      wr(32'h20, 32'h55AA55AA, 4'b0011, 4'd4, blat, bi);
      rd(32'h20, 4'd8, 0, rdv, ri, rlat, aa);
    join
    chk("t5_bypass", rdv, 32'h111155AA);

    awaddr = 32'h40; wdata = 32'hDEADBEEF; wstrb = 4'hF; awid = 4'd7;
    araddr = 32'h30; arid = 4'd3;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t6_rvalid_pre", 32'(rvalid), 1);
    chk("t6_bvalid_pre", 32'(bvalid), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("t6_rvalid_rst", 32'(rvalid), 0);
    chk("t6_bvalid_rst", 32'(bvalid), 0);
    chk("t6_arready_rst", 32'(arready), 0);
    chk("t6_rid_rst", 32'(rid), 0);
    resetn = 1'b1;
    @(negedge clk);
    rd(32'h40, 4'd2, 0, rdv, ri, rlat, aa);
    chk("t6_persist_new", rdv, 32'hDEADBEEF);
    rd(32'h10, 4'd2, 0, rdv, ri, rlat, aa);
    chk("t6_persist_old", rdv, 32'h12BB56DD);
`endif

`ifdef AXI_SLV_STALL_EN
    nops = 200;
`else
    nops = 40;
`endif
    for (int i = 0; i < 16; i++) begin
      mdl[i] = 32'h5000_0000 + 32'(i) * 32'h0101_0101;
      wr(32'h400 + 32'(i) * 4, mdl[i], 4'hF, 4'(i), blat, bi);
      chk("rnd_init_bid", 32'(bi), 32'(i));
    end
    for (int i = 0; i < nops; i++) begin
      k = int'($urandom_range(0, 15));
      a = ($urandom & 32'hFFFF_C000) | (32'h400 + 32'(k) * 4)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom);
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl[k][8*b +: 8] = d[8*b +: 8];
        wr(a, d, s, 4'(k), blat, bi);
        chk("rnd_bid", 32'(bi), 32'(k));
      end else begin
        e = mdl[k];
        rd(a, 4'(k), int'($urandom_range(0, 2)), rdv, ri, rlat, aa);
        chk("rnd_rdata", rdv, e);
        chk("rnd_rid", 32'(ri), 32'(k));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
